// File: rtl/falafel_pkg.sv
// Shared falafel allocator types and constants: front-end arbiter entry format,
// op encodings and a helper for index widths.
package falafel_pkg;

  localparam int MSG_ID_SIZE = 8;
  localparam int DATA_W      = 32;
  localparam int ARB_STAT_W  = 16;

  localparam logic ARB_OP_ALLOC = 1'b0;
  localparam logic ARB_OP_FREE  = 1'b1;

  typedef struct packed {
    logic                   op;
    logic [MSG_ID_SIZE-1:0] id;
    logic [DATA_W-1:0]      data;
  } arb_entry_t;

  // Width of an index into n items; never zero so single-entry structures still elaborate.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/falafel_rr_arb.sv
// Round-robin arbiter over N requesters: grants the first request at or after
// the pointer and moves the pointer just past the winner.
module falafel_rr_arb
  import falafel_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          srst,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  logic [IW-1:0] ptr_reg;
  logic [IW-1:0] ptr_next;
  logic [IW-1:0] cand_idx;
  int            cand;

  // Scan offsets high to low so the lowest offset from the pointer wins last.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    gnt_vld  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = int'(ptr_reg) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = IW'(cand);
      if (en && req[cand_idx]) begin
        gnt_vld       = 1'b1;
        gnt_idx       = cand_idx;
        gnt           = '0;
        gnt[cand_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (gnt_vld) ptr_next = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (srst) ptr_reg <= '0;
    else      ptr_reg <= ptr_next;
  end

endmodule

// File: rtl/falafel_rr_input_arbiter.sv
// Per-channel request FIFOs drained by independent round-robin alloc and free arbiters.
// Optional FALAFEL_ARB_STATS_EN adds saturating per-channel grant counters (grant_cnt_o).
module falafel_rr_input_arbiter
  import falafel_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int BUF_DEPTH = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_CH-1:0]                   req_val_i,
  output logic [NUM_CH-1:0]                   req_rdy_o,
  input  logic [NUM_CH-1:0]                   req_op_i,
  input  logic [NUM_CH-1:0][MSG_ID_SIZE-1:0]  req_id_i,
  input  logic [NUM_CH-1:0][DATA_W-1:0]       req_data_i,
  input  logic                                alloc_fifo_full_i,
  output logic                                alloc_fifo_write_o,
  output logic [DATA_W-1:0]                   alloc_fifo_din_size_o,
  output logic [MSG_ID_SIZE-1:0]              alloc_fifo_din_id_o,
  input  logic                                free_fifo_full_i,
  output logic                                free_fifo_write_o,
  output logic [DATA_W-1:0]                   free_fifo_din_o
`ifdef FALAFEL_ARB_STATS_EN
  ,
  output logic [NUM_CH-1:0][ARB_STAT_W-1:0]   grant_cnt_o
`endif
);

  localparam int PW = idx_w(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int IW = idx_w(NUM_CH);

  arb_entry_t        head [NUM_CH];
  logic [NUM_CH-1:0] alloc_req;
  logic [NUM_CH-1:0] free_req;
  logic [NUM_CH-1:0] alloc_gnt;
  logic [NUM_CH-1:0] free_gnt;
  logic [IW-1:0]     alloc_idx;
  logic [IW-1:0]     free_idx;
  logic              alloc_vld;
  logic              free_vld;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      arb_entry_t     mem_reg [BUF_DEPTH];
      logic [PW-1:0]  wr_ptr_reg;
      logic [PW-1:0]  rd_ptr_reg;
      logic [CW-1:0]  count_reg;
      logic           push;
      logic           pop;

      // Ready looks only at occupancy, so a source may never see it combinationally follow its valid.
      assign req_rdy_o[gi] = ~rst_i & (count_reg < CW'(BUF_DEPTH));
      assign push          = req_val_i[gi] & req_rdy_o[gi];
      assign pop           = alloc_gnt[gi] | free_gnt[gi];
      assign head[gi]      = mem_reg[rd_ptr_reg];
      assign alloc_req[gi] = (count_reg != '0) && (head[gi].op == ARB_OP_ALLOC);
      assign free_req[gi]  = (count_reg != '0) && (head[gi].op == ARB_OP_FREE);

      always_ff @(posedge clk_i) begin
        if (push) mem_reg[wr_ptr_reg] <= '{op: req_op_i[gi], id: req_id_i[gi], data: req_data_i[gi]};
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push) wr_ptr_reg <= (wr_ptr_reg == PW'(BUF_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
          if (pop)  rd_ptr_reg <= (rd_ptr_reg == PW'(BUF_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
          if (push && !pop)      count_reg <= count_reg + 1'b1;
          else if (!push && pop) count_reg <= count_reg - 1'b1;
        end
      end

`ifdef FALAFEL_ARB_STATS_EN
      logic [ARB_STAT_W-1:0] grant_cnt_reg;
      always_ff @(posedge clk_i) begin
        if (rst_i)                           grant_cnt_reg <= '0;
        else if (pop && grant_cnt_reg != '1) grant_cnt_reg <= grant_cnt_reg + 1'b1;
      end
      assign grant_cnt_o[gi] = grant_cnt_reg;
`endif
    end
  endgenerate

  falafel_rr_arb #(.N(NUM_CH)) u_alloc_arb (
    .clk     (clk_i),
    .srst    (rst_i),
    .req     (alloc_req),
    .en      (~alloc_fifo_full_i & ~rst_i),
    .gnt     (alloc_gnt),
    .gnt_idx (alloc_idx),
    .gnt_vld (alloc_vld)
  );

  falafel_rr_arb #(.N(NUM_CH)) u_free_arb (
    .clk     (clk_i),
    .srst    (rst_i),
    .req     (free_req),
    .en      (~free_fifo_full_i & ~rst_i),
    .gnt     (free_gnt),
    .gnt_idx (free_idx),
    .gnt_vld (free_vld)
  );

  always_comb begin
    alloc_fifo_write_o    = alloc_vld;
    alloc_fifo_din_size_o = alloc_vld ? head[alloc_idx].data : '0;
    alloc_fifo_din_id_o   = alloc_vld ? head[alloc_idx].id   : '0;
    free_fifo_write_o     = free_vld;
    free_fifo_din_o       = free_vld ? head[free_idx].data : '0;
  end

endmodule

// File: tb/tb_falafel_rr_input_arbiter.sv
// Randomized and directed bench for falafel_rr_input_arbiter, checked by a queue-based
// reference model and a scoreboard monitor sampling on the falling edge.
module tb_falafel_rr_input_arbiter;
  import falafel_pkg::*;

  localparam int NUM_CH    = 4;
  localparam int BUF_DEPTH = 2;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic                               rst;
  logic [NUM_CH-1:0]                  req_val;
  logic [NUM_CH-1:0]                  req_rdy;
  logic [NUM_CH-1:0]                  req_op;
  logic [NUM_CH-1:0][MSG_ID_SIZE-1:0] req_id;
  logic [NUM_CH-1:0][DATA_W-1:0]      req_data;
  logic                               afull, ffull;
  logic                               awrite, fwrite;
  logic [DATA_W-1:0]                  asize, faddr;
  logic [MSG_ID_SIZE-1:0]             aid;
`ifdef FALAFEL_ARB_STATS_EN
  logic [NUM_CH-1:0][ARB_STAT_W-1:0]  grant_cnt;
  int                                 gcnt [NUM_CH];
`endif

  falafel_rr_input_arbiter #(.NUM_CH(NUM_CH), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .req_val_i             (req_val),
    .req_rdy_o             (req_rdy),
    .req_op_i              (req_op),
    .req_id_i              (req_id),
    .req_data_i            (req_data),
    .alloc_fifo_full_i     (afull),
    .alloc_fifo_write_o    (awrite),
    .alloc_fifo_din_size_o (asize),
    .alloc_fifo_din_id_o   (aid),
    .free_fifo_full_i      (ffull),
    .free_fifo_write_o     (fwrite),
    .free_fifo_din_o       (faddr)
`ifdef FALAFEL_ARB_STATS_EN
    ,
    .grant_cnt_o           (grant_cnt)
`endif
  );

  typedef struct {
    int                     cyc;
    logic [DATA_W-1:0]      data;
    logic [MSG_ID_SIZE-1:0] id;
  } exp_t;

  exp_t       aexp [$];
  exp_t       fexp [$];
  arb_entry_t chq  [NUM_CH][$];
  arb_entry_t acc_ent [NUM_CH];
  logic [NUM_CH-1:0] acc, rdy_exp;
  int  aptr, fptr, a_g, f_g, cyc;
  logic prev_rst;
  int  n_cmp, n_bad;
  bit  started;

  // Reference: decide this cycle's grants and acceptances from the model queues.
  task automatic predict();
    exp_t e;
    rdy_exp = '0;
    a_g = -1;
    f_g = -1;
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++) rdy_exp[c] = (chq[c].size() < BUF_DEPTH);
      for (int k = 0; k < NUM_CH; k++) begin
        int c;
        c = (aptr + k) % NUM_CH;
        if (!afull && a_g < 0 && chq[c].size() > 0 && chq[c][0].op == ARB_OP_ALLOC) a_g = c;
      end
      for (int k = 0; k < NUM_CH; k++) begin
        int c;
        c = (fptr + k) % NUM_CH;
        if (!ffull && f_g < 0 && chq[c].size() > 0 && chq[c][0].op == ARB_OP_FREE) f_g = c;
      end
      if (a_g >= 0) begin
        e.cyc = cyc; e.data = chq[a_g][0].data; e.id = chq[a_g][0].id;
        aexp.push_back(e);
      end
      if (f_g >= 0) begin
        e.cyc = cyc; e.data = chq[f_g][0].data; e.id = '0;
        fexp.push_back(e);
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      acc[c]     = req_val[c] & rdy_exp[c];
      acc_ent[c] = '{op: req_op[c], id: req_id[c], data: req_data[c]};
    end
    prev_rst = rst;
  endtask

  task automatic apply_edge();
    if (prev_rst) begin
      for (int c = 0; c < NUM_CH; c++) chq[c].delete();
      aptr = 0;
      fptr = 0;
`ifdef FALAFEL_ARB_STATS_EN
      for (int c = 0; c < NUM_CH; c++) gcnt[c] = 0;
`endif
    end else begin
      if (a_g >= 0) begin
        void'(chq[a_g].pop_front());
        aptr = (a_g + 1) % NUM_CH;
`ifdef FALAFEL_ARB_STATS_EN
        if (gcnt[a_g] < 65535) gcnt[a_g]++;
`endif
      end
      if (f_g >= 0) begin
        void'(chq[f_g].pop_front());
        fptr = (f_g + 1) % NUM_CH;
`ifdef FALAFEL_ARB_STATS_EN
        if (gcnt[f_g] < 65535) gcnt[f_g]++;
`endif
      end
      for (int c = 0; c < NUM_CH; c++) if (acc[c]) chq[c].push_back(acc_ent[c]);
    end
    cyc++;
  endtask

  task automatic cycle();
    predict();
    @(posedge clk);
    #1;
    apply_edge();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rst = 1'b0;
      req_val = '0;
      cycle();
    end
  endtask

  task automatic push1(input int c, input logic op, input int id, input int data);
    rst = 1'b0;
    req_val = '0;
    req_val[c] = 1'b1;
    req_op[c] = op;
    req_id[c] = MSG_ID_SIZE'(id);
    req_data[c] = DATA_W'(data);
    cycle();
  endtask

  // Monitor: compares what the DUT presents against the scoreboard.
  always @(negedge clk) begin
    if (started) begin
      n_cmp++;
      if (req_rdy !== rdy_exp) begin
        n_bad++;
        $display("FAIL rdy cyc=%0d got=%b exp=%b", cyc, req_rdy, rdy_exp);
      end
      n_cmp++;
      if (awrite === 1'b1) begin
        if (aexp.size() == 0 || aexp[0].cyc != cyc) begin
          n_bad++;
          $display("FAIL alloc_unexpected cyc=%0d got size=%h id=%h exp none", cyc, asize, aid);
        end else begin
          exp_t e;
          e = aexp.pop_front();
          if (asize !== e.data || aid !== e.id) begin
            n_bad++;
            $display("FAIL alloc_data cyc=%0d got size=%h id=%h exp size=%h id=%h", cyc, asize, aid, e.data, e.id);
          end
        end
      end else begin
        if (awrite !== 1'b0 || asize !== '0 || aid !== '0) begin
          n_bad++;
          $display("FAIL alloc_idle cyc=%0d got wr=%b size=%h id=%h exp 0", cyc, awrite, asize, aid);
        end else if (aexp.size() > 0 && aexp[0].cyc == cyc) begin
          n_bad++;
          $display("FAIL alloc_missed cyc=%0d got no strobe exp size=%h", cyc, aexp[0].data);
          void'(aexp.pop_front());
        end
      end
      n_cmp++;
      if (fwrite === 1'b1) begin
        if (fexp.size() == 0 || fexp[0].cyc != cyc) begin
          n_bad++;
          $display("FAIL free_unexpected cyc=%0d got addr=%h exp none", cyc, faddr);
        end else begin
          exp_t e;
          e = fexp.pop_front();
          if (faddr !== e.data) begin
            n_bad++;
            $display("FAIL free_data cyc=%0d got addr=%h exp addr=%h", cyc, faddr, e.data);
          end
        end
      end else begin
        if (fwrite !== 1'b0 || faddr !== '0) begin
          n_bad++;
          $display("FAIL free_idle cyc=%0d got wr=%b addr=%h exp 0", cyc, fwrite, faddr);
        end else if (fexp.size() > 0 && fexp[0].cyc == cyc) begin
          n_bad++;
          $display("FAIL free_missed cyc=%0d got no strobe exp addr=%h", cyc, fexp[0].data);
          void'(fexp.pop_front());
        end
      end
    end
  end

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; aptr = 0; fptr = 0;
    rst = 1'b1; req_val = '0; req_op = '0; req_id = '0; req_data = '0;
    afull = 1'b0; ffull = 1'b0;
    #1;
    started = 1'b1;

    for (int i = 0; i < 3; i++) cycle();          // reset held
    idle(2);

    push1(2, ARB_OP_ALLOC, 5, 'h40);              // single alloc
    idle(3);

    for (int i = 0; i < 24; i++) begin            // round-robin, all channels
      rst = 1'b0;
      req_val = '1;
      for (int c = 0; c < NUM_CH; c++) begin
        req_op[c] = ARB_OP_ALLOC;
        req_id[c] = MSG_ID_SIZE'(c);
        req_data[c] = DATA_W'(i * 16 + c);
      end
      cycle();
    end
    idle(4);

    afull = 1'b1;                                 // backpressure on ch0
    for (int i = 0; i < 4; i++) push1(0, ARB_OP_ALLOC, i, 'h100 + i);
    idle(2);
    afull = 1'b0;
    idle(4);

    rst = 1'b0;                                   // concurrent alloc and free
    req_val = 4'b1010;
    req_op[1] = ARB_OP_ALLOC; req_id[1] = 8'd1; req_data[1] = 32'h10;
    req_op[3] = ARB_OP_FREE;  req_id[3] = 8'd0; req_data[3] = 32'h800;
    cycle();
    idle(3);

    ffull = 1'b1;                                 // free head blocks alloc, then reset
    push1(0, ARB_OP_FREE, 0, 'h100);
    push1(0, ARB_OP_ALLOC, 3, 'h20);
    idle(3);
    rst = 1'b1; req_val = '0;
    cycle();
    ffull = 1'b0;
    idle(4);

    for (int i = 0; i < 1500; i++) begin          // randomized traffic
      rst   = ($urandom_range(0, 99) == 0);
      afull = ($urandom_range(0, 9) < 3);
      ffull = ($urandom_range(0, 9) < 3);
      for (int c = 0; c < NUM_CH; c++) begin
        req_val[c]  = $urandom_range(0, 1);
        req_op[c]   = $urandom_range(0, 1);
        req_id[c]   = MSG_ID_SIZE'($urandom);
        req_data[c] = $urandom;
      end
      cycle();
    end
    afull = 1'b0; ffull = 1'b0;
    idle(12);

    n_cmp++;
    if (aexp.size() != 0 || fexp.size() != 0) begin
      n_bad++;
      $display("FAIL leftover got alloc=%0d free=%0d pending exp 0", aexp.size(), fexp.size());
    end
`ifdef FALAFEL_ARB_STATS_EN
    for (int c = 0; c < NUM_CH; c++) begin
      n_cmp++;
      if (int'(grant_cnt[c]) != gcnt[c]) begin
        n_bad++;
        $display("FAIL grant_cnt ch=%0d got=%0d exp=%0d", c, grant_cnt[c], gcnt[c]);
      end
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/falafel_rr_input_arbiter.md
Name: falafel_rr_input_arbiter

Overview:
Next-generation front-end arbiter of the falafel allocator. It accepts alloc/free requests from NUM_CH uniform channels and buffers each channel in a small FIFO. Two independent round-robin arbiters drain the buffer heads into the allocator's alloc FIFO and free FIFO, replacing fixed-priority selection with starvation-free fairness. It sits between the request sources and the alloc/free FIFOs feeding the allocator core.

Parameters:
NUM_CH, 4, number of request channels (>=1)
BUF_DEPTH, 2, entries per channel buffer (>=1, any integer)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock, reset is synchronous and active-high
req_val_i  in  1 x NUM_CH  per-channel request valid
req_rdy_o  out  1 x NUM_CH  per-channel ready (buffer not full)
req_op_i  in  1 x NUM_CH  request kind: 0 = alloc, 1 = free
req_id_i  in  MSG_ID_SIZE x NUM_CH  message id (alloc only; ignored for free)
req_data_i  in  DATA_W x NUM_CH  alloc size or free address
alloc_fifo_full_i  in  1  alloc FIFO full
alloc_fifo_write_o  out  1  alloc FIFO write strobe
alloc_fifo_din_size_o  out  DATA_W  alloc size
alloc_fifo_din_id_o  out  MSG_ID_SIZE  alloc id
free_fifo_full_i  in  1  free FIFO full
free_fifo_write_o  out  1  free FIFO write strobe
free_fifo_din_o  out  DATA_W  free address

Behaviour:
- Reset (rst_i high at a clock edge): all buffers emptied, both RR pointers = 0. While rst_i is high: req_rdy_o = 0, both write strobes = 0, data outputs = 0. Reset mid-operation discards buffered entries. No partial writes result.
- Channel buffer: FIFO of BUF_DEPTH entries {op, id, data}, with a count register.
  - req_rdy_o[c] = (count < BUF_DEPTH) and not reset. It depends on state only, never on req_val_i.
  - Push on val & rdy.
  - Simultaneous push and pop: count unchanged. Pointers wrap modulo BUF_DEPTH.
  - Push while full: impossible by protocol, because rdy is low.
- Latency: an entry accepted at edge t is eligible at the head during cycle t+1. There is no same-cycle bypass.
- Alloc arbiter (combinational grant):
  - Candidates: channels whose buffer is non-empty and whose head op = 0.
  - If alloc_fifo_full_i = 0 and any candidate exists, grant the first candidate at or after alloc_ptr, scanning upward modulo NUM_CH.
  - On grant: alloc_fifo_write_o = 1, size/id = head fields, pop that head at the edge, alloc_ptr <= (grant+1) mod NUM_CH.
  - Otherwise: write = 0, outputs = 0, pointer held.
- Free arbiter: identical, using op = 1, free_ptr, free_fifo_full_i and free_fifo_write_o. free_fifo_din_o = head data.
- Both arbiters may grant in the same cycle. They always grant different channels, since a head has one op.
- Each channel is served in order: a free head blocks later alloc entries of the same channel. Program order per channel is preserved.
- Full FIFO: no strobe and no pops. Pointers hold, and heads remain stable until granted.
- Fairness bound: with all NUM_CH channels continuously requesting one op, each is granted at least once every NUM_CH grants of that op.

Optional Feature:
FALAFEL_ARB_STATS_EN
- Defined: adds output grant_cnt_o, 16 bits x NUM_CH. Each is a per-channel saturating count of grants across both arbiters; a dual grant to different channels increments both. Reset to 0; holds at 16'hFFFF.
- Undefined: port and counters absent. Arbitration behaviour is identical.

Decomposition:
- falafel_pkg additions:
  - arb_entry_t {op, id[MSG_ID_SIZE], data[DATA_W]}
  - localparam ARB_OP_ALLOC = 1'b0, ARB_OP_FREE = 1'b1
  - ARB_STAT_W = 16
- Sub-module falafel_rr_arb (parameter N): request vector and enable in; one-hot grant, grant index and valid out; owns the RR pointer and its update. Instantiated twice.
- Channel FIFOs are a generate loop inside the top.

Test Plan:
- Reset/idle: rst_i held 3 cycles -> all rdy 0, strobes 0. After release, rdy = 1 on all channels and no strobe.
- Single alloc: ch2 pushes op 0, id 5, data 0x40 at edge t -> cycle t+1: alloc_fifo_write_o = 1, size 0x40, id 5. Next cycle write = 0 and alloc_ptr = 3.
- Round-robin: all 4 channels keep pushing allocs, FIFO never full -> grant sequence 0,1,2,3,0,... with no channel skipped.
- Backpressure: BUF_DEPTH = 2, ch0 pushes 3 allocs with alloc_fifo_full_i = 1 -> rdy[0] drops after 2 pushes and no strobe. Releasing full -> entries emerge in push order, and rdy[0] rises after the first pop.
- Concurrent ops: ch1 head alloc (size 0x10), ch3 head free (addr 0x800), both FIFOs not full -> same cycle: alloc write (0x10) and free write (0x800).
- Ordering plus reset: ch0 pushes free 0x100 then alloc 0x20 while free_fifo_full_i = 1 -> no alloc strobe (blocked behind the free head). Asserting rst_i mid-stall -> buffer empty, no strobes after release.
